// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data BRAM between the CPU MEM stage and a debug/loader port.
// CPU has fixed priority; a saturating starvation counter forces one debug grant after STARVE_LIMIT losses.
module dmem_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CPU_CLK,
  input  logic              CPU_RST,
  input  logic              cpu_req,
  input  logic [3:0]        cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              dbg_req,
  input  logic [3:0]        dbg_we,
  input  logic [31:0]       dbg_addr,
  input  logic [31:0]       dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [31:0]       dbg_rdata,
  output logic              mem_en,
  output logic [3:0]        mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic {NORMAL, FORCE} arb_state_t;

  arb_state_t state_reg;
  logic [3:0] starve_cnt;
  logic [3:0] starve_next;
  logic       rd_cpu;
  logic       rd_dbg;
  logic       force_dbg;
  logic       cpu_gnt;

  // state_reg is FORCE exactly when starve_cnt == LIMIT, so it serves as the force term.
  assign force_dbg = dbg_req & (state_reg == FORCE);
  assign dbg_gnt   = dbg_req & (~cpu_req | force_dbg);
  assign cpu_gnt   = cpu_req & ~force_dbg;
  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign mem_en    = cpu_gnt | dbg_gnt;

  always_comb begin
    mem_we    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr[ADDR_W+1:2];
      mem_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[ADDR_W+1:2];
      mem_wdata = dbg_wdata;
    end
  end

  always_comb begin
    starve_next = 4'd0;
    if (dbg_req && !dbg_gnt)
      starve_next = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
  end

  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST) begin
      starve_cnt <= 4'd0;
      state_reg  <= NORMAL;
      rd_cpu     <= 1'b0;
      rd_dbg     <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      state_reg  <= (starve_next == LIMIT) ? FORCE : NORMAL;
      rd_cpu     <= cpu_gnt & (cpu_we == 4'b0000);
      rd_dbg     <= dbg_gnt & (dbg_we == 4'b0000);
    end
  end

  assign cpu_rvalid = rd_cpu;
  assign dbg_rvalid = rd_dbg;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

  // Byte-offset and out-of-range address bits are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                              dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic against a cycle reference model
// that tracks debug losses, expected memory contents and outstanding read returns.
module tb_dmem_arbiter;
  localparam int ADDR_W = 12;
  localparam int LIMIT  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req, dbg_req;
  logic [3:0]        cpu_we, dbg_we;
  logic [31:0]       cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
  logic              cpu_stall, cpu_rvalid, dbg_gnt, dbg_rvalid;
  logic [31:0]       cpu_rdata, dbg_rdata;
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .CPU_CLK(clk), .CPU_RST(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // BRAM environment: byte-write, registered read.
  logic [31:0] bram [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= bram[mem_addr];
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) bram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] shadow [0:(1<<ADDR_W)-1];
  int          losses;
  bit          exp_cpu_rv, exp_dbg_rv;
  logic [31:0] exp_rdata;
  bit          exp_cpu_g, exp_dbg_g;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] we);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // One clock: check outputs at negedge, then advance the model at posedge.
  task automatic cycle();
    bit          win_dbg;
    logic [3:0]  e_we;
    logic [31:0] e_addr, e_wd;
    int          w;
    win_dbg   = dbg_req && (losses >= LIMIT);
    exp_dbg_g = dbg_req && (!cpu_req || win_dbg);
    exp_cpu_g = cpu_req && !win_dbg;
    e_we = 4'b0; e_addr = 32'h0; e_wd = 32'h0;
    if (exp_cpu_g) begin e_we = cpu_we; e_addr = cpu_addr; e_wd = cpu_wdata; end
    else if (exp_dbg_g) begin e_we = dbg_we; e_addr = dbg_addr; e_wd = dbg_wdata; end
    w = int'((e_addr >> 2) % (1 << ADDR_W));
    @(negedge clk);
    check("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !exp_cpu_g));
    check("dbg_gnt", 32'(dbg_gnt), 32'(exp_dbg_g));
    check("mem_en", 32'(mem_en), 32'(exp_cpu_g || exp_dbg_g));
    check("mem_we", 32'(mem_we), 32'(e_we));
    check("mem_addr", 32'(mem_addr), (exp_cpu_g || exp_dbg_g) ? 32'(w) : 32'h0);
    check("mem_wdata", mem_wdata, e_wd);
    check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cpu_rv));
    check("dbg_rvalid", 32'(dbg_rvalid), 32'(exp_dbg_rv));
    if (exp_cpu_rv) check("cpu_rdata", cpu_rdata, exp_rdata);
    if (exp_dbg_rv) check("dbg_rdata", dbg_rdata, exp_rdata);
    check("starve_cnt", 32'(dut.starve_cnt), 32'(losses));
    @(posedge clk);
    if (exp_cpu_g || exp_dbg_g) begin
      if (e_we == 4'b0000) exp_rdata = shadow[w];
      else shadow[w] = merge(shadow[w], e_wd, e_we);
    end
    if (rst) begin
      losses = 0; exp_cpu_rv = 0; exp_dbg_rv = 0;
    end else begin
      exp_cpu_rv = exp_cpu_g && (cpu_we == 4'b0000);
      exp_dbg_rv = exp_dbg_g && (dbg_we == 4'b0000);
      if (!dbg_req || exp_dbg_g) losses = 0;
      else if (losses < LIMIT) losses++;
    end
    $display("cyc t=%0t rst=%0b cpu(req=%0b we=%h a=%h) dbg(req=%0b we=%h a=%h) gnt cpu=%0b dbg=%0b",
             $time, rst, cpu_req, cpu_we, cpu_addr, dbg_req, dbg_we, dbg_addr, exp_cpu_g, exp_dbg_g);
    #1;
  endtask

  task automatic drive(input bit r, input bit cr, input logic [3:0] cw, input logic [31:0] ca,
                       input logic [31:0] cd, input bit dr, input logic [3:0] dw,
                       input logic [31:0] da, input logic [31:0] dd);
    rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_addr = da; dbg_wdata = dd;
    cycle();
  endtask

  function automatic logic [3:0] rand_we();
    logic [3:0] opts [5] = '{4'b0000, 4'b0000, 4'b0001, 4'b0011, 4'b1111};
    return opts[$urandom_range(0, 4)];
  endfunction

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  bit cpu_hold, dbg_hold;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin bram[i] = 32'h0; shadow[i] = 32'h0; end
    mem_rdata = 32'h0; losses = 0; exp_cpu_rv = 0; exp_dbg_rv = 0; exp_rdata = 0;
    #1;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    // CPU store then load of 0x104.
    drive(0, 1, 4'b0011, 32'h104, 32'h0000BEEF, 0, 0, 0, 0);
    drive(0, 1, 4'b0000, 32'h104, 32'h0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("store_load_data", cpu_rdata, 32'h0000BEEF);
    // Debug-only read of 0x200.
    drive(0, 0, 0, 0, 0, 1, 4'b0000, 32'h200, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Starvation: debug read forced in cycle 4, CPU read next.
    drive(0, 1, 4'b1111, 32'h300, 32'hCAFE0001, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) drive(0, 1, 4'b1111, 32'h10, 32'h1111_0000 + c, 1, 4'b0000, 32'h300, 0);
    check("force_loss_count", 32'(losses), 32'(LIMIT));
    drive(0, 1, 4'b0000, 32'h10, 0, 1, 4'b0000, 32'h300, 0);
    drive(0, 1, 4'b0000, 32'h10, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Debug drops at count 2 and is re-raised: counter restarts.
    drive(0, 1, 0, 32'h20, 0, 1, 4'b0001, 32'h24, 32'hAB);
    drive(0, 1, 0, 32'h20, 0, 1, 4'b0001, 32'h24, 32'hAB);
    drive(0, 1, 0, 32'h20, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) drive(0, 1, 0, 32'h20, 0, 1, 4'b0001, 32'h24, 32'hAB);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // CPU read granted while reset is asserted never returns rvalid.
    drive(1, 1, 4'b0000, 32'h104, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // Randomized traffic.
    cpu_hold = 0; dbg_hold = 0;
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!cpu_hold) begin
        cpu_req = ($urandom_range(0, 3) != 0);
        cpu_we = rand_we(); cpu_addr = rand_addr(); cpu_wdata = $urandom;
      end
      if (!dbg_hold) begin
        dbg_req = ($urandom_range(0, 2) == 0);
        dbg_we = rand_we(); dbg_addr = rand_addr(); dbg_wdata = $urandom;
      end
      cycle();
      cpu_hold = cpu_req && !exp_cpu_g && !rst;
      dbg_hold = dbg_req && !exp_dbg_g && !rst;
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data BRAM between the CPU MEM stage and a debug/loader port; one access per cycle.
- CPU has fixed priority. A starvation counter forces a debug grant after STARVE_LIMIT consecutive lost cycles.
- Drives the pipeline stall and routes 1-cycle-latency read data back to the owner of each read.
- Sits between the MEM stage (byte-enable store mask as produced by decode: 0001/0011/1111) and the data memory.

Parameters:
- ADDR_W, 12, word-address width of the data BRAM.
- STARVE_LIMIT, 4, consecutive cycles debug may lose arbitration before it is forced through (1..15).

Ports:
- CPU_CLK  in  1  clock, rising edge.
- CPU_RST  in  1  synchronous active-high reset.
- cpu_req  in  1  MEM-stage access request (load or store).
- cpu_we  in  4  byte write enables; 0000 = read.
- cpu_addr  in  32  byte address.
- cpu_wdata  in  32  store data, already lane-aligned.
- cpu_stall  out  1  high when cpu_req is high and the CPU is not granted this cycle.
- cpu_rvalid  out  1  read data valid for the CPU (one cycle after the granted read).
- cpu_rdata  out  32  read data.
- dbg_req  in  1  debug access request; held stable until dbg_gnt.
- dbg_we  in  4  byte write enables; 0000 = read.
- dbg_addr  in  32  byte address.
- dbg_wdata  in  32  write data.
- dbg_gnt  out  1  debug access issued this cycle.
- dbg_rvalid  out  1  read data valid for debug.
- dbg_rdata  out  32  read data.
- mem_en  out  1  BRAM enable.
- mem_we  out  4  BRAM byte write enables.
- mem_addr  out  ADDR_W  BRAM word address = granted addr[ADDR_W+1:2].
- mem_wdata  out  32  BRAM write data.
- mem_rdata  in  32  BRAM read data, valid the cycle after a read is issued.

Behaviour:
- Grant is combinational from the requests plus the registered starve_cnt (4 bits):
  - force = dbg_req & (starve_cnt == STARVE_LIMIT).
  - dbg_gnt = dbg_req & (~cpu_req | force).
  - cpu_gnt (internal) = cpu_req & ~force.
  - cpu_stall = cpu_req & ~cpu_gnt.
- Memory side:
  - mem_en = cpu_gnt | dbg_gnt.
  - mem_we, mem_addr and mem_wdata are muxed from the granted requester.
  - With no grant: mem_we = 0000, mem_addr = 0, mem_wdata = 0.
  - Address bits [1:0] and bits above ADDR_W+1 are ignored; there is no misalignment check.
- Writes complete in the grant cycle and produce no rvalid.
- Reads are tracked by registered tags rd_cpu and rd_dbg:
  - On a granted read (we == 0000) the owner's tag is set for one cycle; otherwise tags are 0.
  - cpu_rvalid = rd_cpu and dbg_rvalid = rd_dbg.
  - cpu_rdata = dbg_rdata = mem_rdata, so both are valid only when the matching rvalid is high.
- starve_cnt update, each clock:
  - 0 if dbg_req is low or dbg_gnt is high.
  - Otherwise it increments, saturating at STARVE_LIMIT.
- Arbiter FSM, two states, derived from starve_cnt:
  - NORMAL (starve_cnt < STARVE_LIMIT): CPU priority.
  - FORCE (starve_cnt == STARVE_LIMIT): debug wins; lasts exactly one cycle, then the count returns to 0.
- Simultaneous events:
  - Both requests in the same cycle under NORMAL: CPU wins, counter increments.
  - A stalled CPU repeats the same request next cycle; no internal request buffering.
- Reset (CPU_RST high at a clock edge):
  - starve_cnt, rd_cpu and rd_dbg are cleared to 0.
  - Hence cpu_rvalid = dbg_rvalid = 0 in the cycle after reset.
  - A read issued in the cycle reset is asserted never returns rvalid.
  - The combinational outputs follow their inputs; the integration gates cpu_req/dbg_req low during reset.
- Latency: grant 0 cycles; read data 1 cycle after grant; worst-case debug wait STARVE_LIMIT cycles.

Test Plan:
- CPU-only store then load: cpu_we = 0011, addr 0x104, wdata 0x0000BEEF, next cycle a read of 0x104 -> mem_addr = 0x041, mem_we = 0011, cpu_stall = 0 throughout, cpu_rvalid = 1 one cycle after the read, cpu_rdata = 0x????BEEF.
- Debug-only read of 0x200 with cpu_req = 0 -> dbg_gnt = 1 the same cycle, mem_addr = 0x080, dbg_rvalid = 1 next cycle, cpu_rvalid = 0.
- Continuous cpu_req with dbg_req raised at cycle 0, STARVE_LIMIT = 4:
  - cycles 0-3: CPU granted, starve_cnt reaches 4;
  - cycle 4: dbg_gnt = 1 and cpu_stall = 1;
  - cycle 5: CPU granted again, starve_cnt = 0.
- Debug read forced, CPU read granted the next cycle -> dbg_rvalid in cycle 5, cpu_rvalid in cycle 6, never both in the same cycle, correct data routing.
- dbg_req dropped at starve_cnt = 2 and re-raised -> counter restarts at 0; no forced grant until 4 further losses.
- CPU read granted with CPU_RST asserted in that same cycle -> cpu_rvalid = 0 in the next cycle and starve_cnt = 0.
